// File: rtl/multiplier_datapath.sv
// multiplier_datapath: nibble-serial 8x8 multiply datapath stepped by an external controller
//
// Each enabled step multiplies one selected 4x4 nibble pair, shifts the 8-bit partial
// product into place and accumulates it into a 16-bit result; a clear plus four steps
// in the order (00,00) (01,01) (10,01) (11,10) leaves dataa*datab in product.
//
// Ports:
//   clk        rising-edge clock
//   reset_a    asynchronous active-low reset (acc, count, operand registers -> 0)
//   dataa      multiplicand, 2*HALF_W bits
//   datab      multiplier, 2*HALF_W bits
//   input_sel  nibble pair: bit1 picks dataa high nibble, bit0 picks datab high nibble
//   shift_sel  partial shift: 00 <<0, 01 <<HALF_W, 10 <<2*HALF_W, 11 contributes 0
//   clk_ena    step/clear enable; everything holds when low
//   sclr_n     active-low synchronous clear, only honoured while clk_ena is high
//   count      2-bit step counter fed back to the controller, wraps 3->0
//   product    accumulated result, direct register output
//
// Configuration:
//   MULT_DP_OPREG_EN  capture dataa/datab into opa/opb on the clear cycle so the
//                     operands may change after the clear edge; otherwise the steps
//                     read dataa/datab directly and they must stay stable.
module multiplier_datapath #(
    parameter int HALF_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_a,
    input  logic [2*HALF_W-1:0]   dataa,
    input  logic [2*HALF_W-1:0]   datab,
    input  logic [1:0]            input_sel,
    input  logic [1:0]            shift_sel,
    input  logic                  clk_ena,
    input  logic                  sclr_n,
    output logic [1:0]            count,
    output logic [4*HALF_W-1:0]   product
);
    logic [2*HALF_W-1:0] opa, opb;
    logic [HALF_W-1:0]   nib_a, nib_b;
    logic [2*HALF_W-1:0] pp;
    logic [4*HALF_W-1:0] pp_ext, pp_shifted;

`ifdef MULT_DP_OPREG_EN
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            opa <= '0;
            opb <= '0;
        end else if (clk_ena && !sclr_n) begin
            opa <= dataa;
            opb <= datab;
        end
    end
`else
    assign opa = dataa;
    assign opb = datab;
`endif

    assign nib_a  = input_sel[1] ? opa[2*HALF_W-1:HALF_W] : opa[HALF_W-1:0];
    assign nib_b  = input_sel[0] ? opb[2*HALF_W-1:HALF_W] : opb[HALF_W-1:0];
    assign pp     = {{HALF_W{1'b0}}, nib_a} * {{HALF_W{1'b0}}, nib_b};
    assign pp_ext = {{2*HALF_W{1'b0}}, pp};

    // shift_sel=11 is not a legal command; it adds nothing but still counts as a step
    always_comb
        pp_shifted = shift_sel == 2'b00 ? pp_ext :
                     shift_sel == 2'b01 ? pp_ext << HALF_W :
                     shift_sel == 2'b10 ? pp_ext << (2*HALF_W) : '0;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            product <= '0;
            count   <= '0;
        end else if (clk_ena) begin
            if (!sclr_n) begin
                product <= '0;
                count   <= '0;
            end else begin
                product <= product + pp_shifted;
                count   <= count + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_multiplier_datapath.sv
// tb_multiplier_datapath: randomized and directed self-checking bench for multiplier_datapath
module tb_multiplier_datapath;
    logic        clk = 1'b0;
    logic        reset_a = 1'b0;
    logic [7:0]  dataa = '0, datab = '0;
    logic [1:0]  input_sel = '0, shift_sel = '0;
    logic        clk_ena = 1'b0, sclr_n = 1'b1;
    logic [1:0]  count;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;
    bit live = 0;

    multiplier_datapath dut (
        .clk(clk), .reset_a(reset_a), .dataa(dataa), .datab(datab),
        .input_sel(input_sel), .shift_sel(shift_sel), .clk_ena(clk_ena),
        .sclr_n(sclr_n), .count(count), .product(product)
    );

    always #5 clk = ~clk;

    // reference model: plain arithmetic on the selected nibbles
    int m_acc = 0, m_cnt = 0, m_a = 0, m_b = 0;
    always @(posedge clk or negedge reset_a) begin
        int ua, ub, pp;
        if (!reset_a) begin
            m_acc = 0; m_cnt = 0; m_a = 0; m_b = 0;
        end else if (clk_ena) begin
            if (!sclr_n) begin
                m_acc = 0; m_cnt = 0; m_a = int'(dataa); m_b = int'(datab);
            end else begin
`ifdef MULT_DP_OPREG_EN
                ua = m_a; ub = m_b;
`else
                ua = int'(dataa); ub = int'(datab);
`endif
                pp = ((ua >> (4 * int'(input_sel[1]))) % 16) * ((ub >> (4 * int'(input_sel[0]))) % 16);
                m_acc = (m_acc + (shift_sel == 2'b11 ? 0 : pp << (4 * int'(shift_sel)))) % 65536;
                m_cnt = (m_cnt + 1) % 4;
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (live) begin
        chk("model_product", int'(product), m_acc);
        chk("model_count", int'(count), m_cnt);
    end

    task automatic cyc(logic ena, logic sclr, logic [1:0] isel, logic [1:0] ssel);
        @(negedge clk);
        clk_ena = ena; sclr_n = sclr; input_sel = isel; shift_sel = ssel;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(logic [7:0] a, logic [7:0] b);
        dataa = a; datab = b;
        cyc(1, 0, 2'b00, 2'b00);
        cyc(1, 1, 2'b00, 2'b00);
        cyc(1, 1, 2'b01, 2'b01);
        cyc(1, 1, 2'b10, 2'b01);
        cyc(1, 1, 2'b11, 2'b10);
    endtask

    initial begin
        #1;
        chk("reset_product", int'(product), 0);
        chk("reset_count", int'(count), 0);
        #2 reset_a = 1'b1;
        live = 1;

        // 1: 0xFF*0xFF
        run_seq(8'hFF, 8'hFF);
        chk("ff_product", int'(product), 32'hFE01);
        chk("ff_count", int'(count), 0);

        // 2: 0x12*0x34 with partial sums
        dataa = 8'h12; datab = 8'h34;
        cyc(1, 0, 2'b00, 2'b00);
        chk("clear_product", int'(product), 0);
        cyc(1, 1, 2'b00, 2'b00);
        chk("ps1", int'(product), 32'h0008);
        cyc(1, 1, 2'b01, 2'b01);
        chk("ps2", int'(product), 32'h0068);
        // 3: hold with don't-care commands
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 2'bxx, 2'bxx);
            chk("hold_product", int'(product), 32'h0068);
            chk("hold_count", int'(count), 2);
        end
        cyc(1, 1, 2'b10, 2'b01);
        chk("ps3", int'(product), 32'h00A8);
        cyc(1, 1, 2'b11, 2'b10);
        chk("ps4", int'(product), 32'h03A8);
        chk("ps4_count", int'(count), 0);

        // 4: async reset mid-sequence
        dataa = 8'h12; datab = 8'h34;
        cyc(1, 0, 2'b00, 2'b00);
        cyc(1, 1, 2'b00, 2'b00);
        cyc(1, 1, 2'b01, 2'b01);
        #2 reset_a = 1'b0;
        #1;
        chk("async_rst_product", int'(product), 0);
        chk("async_rst_count", int'(count), 0);
        #1 reset_a = 1'b1;
        run_seq(8'h12, 8'h34);
        chk("after_rst_product", int'(product), 32'h03A8);

        // 5: invalid shift adds zero, count wraps
        dataa = 8'h12; datab = 8'h34;
        cyc(1, 0, 2'b00, 2'b00);
        cyc(1, 1, 2'b00, 2'b00);
        cyc(1, 1, 2'b01, 2'b11);
        chk("shift11_product", int'(product), 32'h0008);
        chk("shift11_count", int'(count), 2);
        cyc(1, 1, 2'b10, 2'b01);
        chk("step3_count", int'(count), 3);
        cyc(1, 1, 2'b11, 2'b10);
        chk("wrap_count", int'(count), 0);

        // 6: operand change after the clear edge
        dataa = 8'h12; datab = 8'h34;
        cyc(1, 0, 2'b00, 2'b00);
        dataa = 8'hFF;
        cyc(1, 1, 2'b00, 2'b00);
        cyc(1, 1, 2'b01, 2'b01);
        cyc(1, 1, 2'b10, 2'b01);
        cyc(1, 1, 2'b11, 2'b10);
`ifdef MULT_DP_OPREG_EN
        chk("opreg_product", int'(product), 32'h03A8);
`else
        chk("noreg_product", int'(product), 32'h33CC);
`endif

        // random full products
        for (int i = 0; i < 30; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom); b = 8'($urandom);
            run_seq(a, b);
            chk("rand_full_product", int'(product), int'(a) * int'(b));
        end

        // random command soup, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            logic ena, sclr;
            ena  = ($urandom_range(0, 3) != 0);
            sclr = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) dataa = 8'($urandom);
            if ($urandom_range(0, 7) == 0) datab = 8'($urandom);
            cyc(ena, sclr, 2'($urandom), 2'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #2 reset_a = 1'b0;
                #1 reset_a = 1'b1;
            end
        end

        live = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
